// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 scan driver: shifts one BCM bit plane per pass from a double-buffered frame RAM
// while the previous plane is displayed; buffers swap on frame boundaries via req/ack.
module hub75_bcm_scan_driver #(
   parameter int COLS       = 64,
   parameter int SCAN_LINES = 16,
   parameter int BPC        = 6,
   parameter int CLK_DIV    = 2,
   parameter int BASE_ON    = 8,
   parameter int LINE_W     = $clog2(SCAN_LINES),
   parameter int COL_W      = $clog2(COLS)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   output logic                    rd_en,
   output logic [LINE_W+COL_W:0]   rd_addr,
   input  logic [3*BPC-1:0]        rd_data_top,
   input  logic [3*BPC-1:0]        rd_data_bot,
   input  logic                    swap_req,
   output logic                    swap_ack,
   output logic                    r0,
   output logic                    g0,
   output logic                    b0,
   output logic                    r1,
   output logic                    g1,
   output logic                    b1,
   output logic                    led_clk,
   output logic                    latch,
   output logic                    oe_n,
   output logic [LINE_W-1:0]       line_select,
   output logic                    frame_start
);

   localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TIMER_W = BPC + $clog2(BASE_ON) + 1;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
   localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(SCAN_LINES - 1);
   localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BPC - 1);
   localparam logic [DIV_W-1:0]   LAST_DIV   = DIV_W'(CLK_DIV - 1);
   localparam logic [TIMER_W-1:0] BASE_TIME  = TIMER_W'(BASE_ON);
   localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DISP, LATCH} state_t;
   typedef enum logic [2:0] {STEP_START, STEP_READ, STEP_DATA, STEP_LOW, STEP_HIGH} step_t;

   state_t              state;
   step_t               step;
   logic [COL_W-1:0]    col;
   logic [LINE_W-1:0]   line;
   logic [PLANE_W-1:0]  plane;
   logic [DIV_W-1:0]    div_cnt;
   logic [TIMER_W-1:0]  timer;
   logic                buf_sel;

   logic                plane_wrap;
   logic                frame_wrap;
   logic [PLANE_W-1:0]  next_plane;
   logic [LINE_W-1:0]   next_line;
   logic [BPC-1:0]      top_r, top_g, top_b, bot_r, bot_g, bot_b;

   assign rd_addr    = {buf_sel, line, col};
   assign plane_wrap = (plane == LAST_PLANE);
   assign frame_wrap = plane_wrap && (line == LAST_LINE);
   assign next_plane = plane_wrap ? '0 : plane + PLANE_W'(1);
   assign next_line  = !plane_wrap ? line : ((line == LAST_LINE) ? '0 : line + LINE_W'(1));

   assign top_r = rd_data_top[3*BPC-1:2*BPC];
   assign top_g = rd_data_top[2*BPC-1:BPC];
   assign top_b = rd_data_top[BPC-1:0];
   assign bot_r = rd_data_bot[3*BPC-1:2*BPC];
   assign bot_g = rd_data_bot[2*BPC-1:BPC];
   assign bot_b = rd_data_bot[BPC-1:0];

   // The display timer runs independently of the FSM so the next plane shifts while this one shows.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         step        <= STEP_START;
         col         <= '0;
         line        <= '0;
         plane       <= '0;
         div_cnt     <= '0;
         timer       <= '0;
         buf_sel     <= 1'b0;
         line_select <= '0;
         rd_en       <= 1'b0;
         led_clk     <= 1'b0;
         latch       <= 1'b0;
         oe_n        <= 1'b1;
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
         {r0, g0, b0, r1, g1, b1} <= '0;
      end else begin
         swap_ack    <= 1'b0;
         frame_start <= 1'b0;
         latch       <= 1'b0;

         if (timer != '0) begin
            timer <= timer - TIMER_ONE;
            oe_n  <= (timer == TIMER_ONE);
         end

         case (state)
            IDLE: begin
               state       <= SHIFT;
               step        <= STEP_START;
               frame_start <= 1'b1;
               if (swap_req) begin
                  buf_sel  <= ~buf_sel;
                  swap_ack <= 1'b1;
               end
            end

            SHIFT: begin
               case (step)
                  STEP_START: begin
                     rd_en <= 1'b1;
                     step  <= STEP_READ;
                  end
                  STEP_READ: begin
                     rd_en <= 1'b0;
                     step  <= STEP_DATA;
                  end
                  STEP_DATA: begin
                     r0      <= top_r[plane];
                     g0      <= top_g[plane];
                     b0      <= top_b[plane];
                     r1      <= bot_r[plane];
                     g1      <= bot_g[plane];
                     b1      <= bot_b[plane];
                     div_cnt <= '0;
                     step    <= STEP_LOW;
                  end
                  STEP_LOW: begin
                     if (div_cnt == LAST_DIV) begin
                        led_clk <= 1'b1;
                        div_cnt <= '0;
                        step    <= STEP_HIGH;
                     end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                     end
                  end
                  STEP_HIGH: begin
                     if (div_cnt == LAST_DIV) begin
                        led_clk <= 1'b0;
                        div_cnt <= '0;
                        if (col == LAST_COL) begin
                           col   <= '0;
                           state <= WAIT_DISP;
                        end else begin
                           col   <= col + COL_W'(1);
                           rd_en <= 1'b1;
                           step  <= STEP_READ;
                        end
                     end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                     end
                  end
                  default: step <= STEP_START;
               endcase
            end

            WAIT_DISP: begin
               if (timer <= TIMER_ONE) begin
                  latch       <= 1'b1;
                  line_select <= line;
                  state       <= LATCH;
               end
            end

            LATCH: begin
               timer <= BASE_TIME << plane;
               oe_n  <= 1'b0;
               plane <= next_plane;
               line  <= next_line;
               state <= SHIFT;
               step  <= STEP_START;
               if (frame_wrap) begin
                  frame_start <= 1'b1;
                  if (swap_req) begin
                     buf_sel  <= ~buf_sel;
                     swap_ack <= 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Bench for hub75_bcm_scan_driver: table vectors, directed reset/swap sequences and a
// randomized run scored by a pass-level model of the panel output stream.
module tb_hub75_bcm_scan_driver;

   localparam int COLS = 4, SCAN_LINES = 2, BPC = 2, CLK_DIV = 1, BASE_ON = 4, SLOW_ON = 32;
   localparam int LINE_W = 1, COL_W = 2, AW = 1 + LINE_W + COL_W;
   localparam int WORDS = 2 * SCAN_LINES * COLS, PASSES = BPC * SCAN_LINES;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic swap_req = 1'b0;
   logic rd_en, swap_ack, r0, g0, b0, r1, g1, b1, led_clk, latch, oe_n, frame_start;
   logic [AW-1:0] rd_addr;
   logic [LINE_W-1:0] line_select;
   logic [3*BPC-1:0] rd_data_top, rd_data_bot;

   logic s_rd_en, s_swap_ack, s_led_clk, s_latch, s_oe_n, s_frame_start;
   logic [5:0] s_col;
   logic [AW-1:0] s_rd_addr;
   logic [LINE_W-1:0] s_line_select;
   logic [3*BPC-1:0] s_data_top, s_data_bot;

   logic [3*BPC-1:0] mem_top [WORDS];
   logic [3*BPC-1:0] mem_bot [WORDS];

   int n_cmp = 0;
   int n_fail = 0;

   hub75_bcm_scan_driver #(.COLS(COLS), .SCAN_LINES(SCAN_LINES), .BPC(BPC),
                           .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)) dut (
      .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data_top(rd_data_top), .rd_data_bot(rd_data_bot),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .led_clk(led_clk), .latch(latch), .oe_n(oe_n),
      .line_select(line_select), .frame_start(frame_start));

   hub75_bcm_scan_driver #(.COLS(COLS), .SCAN_LINES(SCAN_LINES), .BPC(BPC),
                           .CLK_DIV(CLK_DIV), .BASE_ON(SLOW_ON)) slow_dut (
      .clk(clk), .reset_n(reset_n), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
      .rd_data_top(s_data_top), .rd_data_bot(s_data_bot),
      .swap_req(1'b0), .swap_ack(s_swap_ack),
      .r0(s_col[5]), .g0(s_col[4]), .b0(s_col[3]), .r1(s_col[2]), .g1(s_col[1]), .b1(s_col[0]),
      .led_clk(s_led_clk), .latch(s_latch), .oe_n(s_oe_n),
      .line_select(s_line_select), .frame_start(s_frame_start));

   always #5 clk = ~clk;

   // Frame RAM: synchronous read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_top <= mem_top[rd_addr];
         rd_data_bot <= mem_bot[rd_addr];
      end
      if (s_rd_en) begin
         s_data_top <= mem_top[s_rd_addr];
         s_data_bot <= mem_bot[s_rd_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [5:0] exp_bits(input int idx, input int plane);
      logic [3*BPC-1:0] t, b;
      t = mem_top[idx];
      b = mem_bot[idx];
      return {t[2*BPC+plane], t[BPC+plane], t[plane], b[2*BPC+plane], b[BPC+plane], b[plane]};
   endfunction

   // Pass-level model: pass k shows plane k%BPC of line (k/BPC)%SCAN_LINES.
   int k, e, run_len, run_exp, latched_line, line_k, plane_k, idx;
   bit prev_led, prev_reset, in_run, after_latch, boundary, exp_ack, buf_model;
   logic [5:0] prev_colour, cur_colour;

   always @(negedge clk) begin
      cur_colour = {r0, g0, b0, r1, g1, b1};
      if (!reset_n) begin
         k = 0; e = 0; in_run = 0; after_latch = 0; boundary = 0; buf_model = 0; prev_led = 0;
      end else begin
         line_k  = (k / BPC) % SCAN_LINES;
         plane_k = k % BPC;
         if (!prev_reset) begin
            boundary = 1;
            exp_ack  = swap_req;
         end else if (boundary) begin
            checkOutput("frame_start", frame_start, 1);
            checkOutput("swap_ack", swap_ack, exp_ack);
            if (exp_ack) buf_model = !buf_model;
            checkOutput("buf_sel", rd_addr[AW-1], buf_model);
            boundary = 0;
         end else begin
            checkOutput("stray_pulse", {swap_ack, frame_start}, 0);
         end

         if (led_clk && !prev_led) begin
            if (e < COLS) begin
               idx = int'(buf_model) * SCAN_LINES * COLS + line_k * COLS + e;
               checkOutput($sformatf("colour_k%0d_e%0d", k, e), cur_colour, exp_bits(idx, plane_k));
            end else begin
               checkOutput("extra_edge", e, COLS - 1);
            end
            e++;
         end else if (led_clk && prev_led) begin
            checkOutput("colour_hold", cur_colour, prev_colour);
         end

         if (latch) begin
            checkOutput("latch_oe_n", oe_n, 1);
            checkOutput("latch_line", line_select, line_k);
            checkOutput("edges_per_plane", e, COLS);
            checkOutput("latch_led_low", led_clk, 0);
            run_exp = BASE_ON << plane_k;
            run_len = 0;
            after_latch = 1;
            in_run = 0;
            latched_line = line_k;
            k++;
            e = 0;
            if (k % PASSES == 0) begin
               boundary = 1;
               exp_ack  = swap_req;
            end
         end else if (after_latch) begin
            checkOutput("oe_start", oe_n, 0);
            after_latch = 0;
            in_run = 1;
            run_len = oe_n ? 0 : 1;
         end else if (in_run) begin
            if (!oe_n) begin
               run_len++;
               checkOutput("line_hold", line_select, latched_line);
            end else begin
               checkOutput("oe_len", run_len, run_exp);
               in_run = 0;
            end
         end
      end
      prev_led    = led_clk;
      prev_colour = cur_colour;
      prev_reset  = reset_n;
   end

   // With a long on-time the display period, not the shift, paces the latches.
   int cyc = 0;
   int s_k = 0;
   int s_last = 0;
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         s_k = 0;
      end else if (s_latch) begin
         if (s_k > 0) checkOutput("slow_latch_gap", cyc - s_last, (SLOW_ON << ((s_k - 1) % BPC)) + 1);
         s_last = cyc;
         s_k++;
      end
   end

   task automatic waitLedRise(output bit ok);
      logic last;
      last = led_clk;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (led_clk && !last) begin
            ok = 1;
            break;
         end
         last = led_clk;
      end
   endtask

   typedef struct {
      logic [3*BPC-1:0] top;
      logic [3*BPC-1:0] bot;
      logic [5:0]       exp_p0;
      logic [5:0]       exp_p1;
   } vec_t;
   vec_t vecs[4];

   task automatic applyStimulus(input vec_t v, input int id);
      bit ok;
      @(posedge clk);
      #1 reset_n = 0;
      for (int i = 0; i < WORDS; i++) begin
         mem_top[i] = v.top;
         mem_bot[i] = v.bot;
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      for (int j = 0; j < 2 * COLS; j++) begin
         waitLedRise(ok);
         checkOutput($sformatf("vec%0d_rise%0d_seen", id, j), ok, 1);
         checkOutput($sformatf("vec%0d_rise%0d_bits", id, j), {r0, g0, b0, r1, g1, b1},
                     (j < COLS) ? v.exp_p0 : v.exp_p1);
      end
   endtask

   initial begin
      bit ok;
      int n, acks, starts;

      vecs[0] = '{6'b01_00_00, 6'b00_00_00, 6'b100000, 6'b000000};
      vecs[1] = '{6'b10_01_11, 6'b00_10_01, 6'b011001, 6'b101010};
      vecs[2] = '{6'b11_11_11, 6'b11_11_11, 6'b111111, 6'b111111};
      vecs[3] = '{6'b00_00_00, 6'b01_10_11, 6'b000101, 6'b000011};

      for (int i = 0; i < WORDS; i++) begin
         mem_top[i] = '0;
         mem_bot[i] = '0;
      end
      repeat (3) @(posedge clk);

      for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

      // Reset in the middle of the line-1 display period.
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!oe_n && line_select == 1'b1) begin
            ok = 1;
            break;
         end
      end
      checkOutput("t1_reach_display", ok, 1);
      @(posedge clk);
      #1 reset_n = 0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("t1_oe_n", oe_n, 1);
      checkOutput("t1_latch", latch, 0);
      checkOutput("t1_led_clk", led_clk, 0);
      checkOutput("t1_line_select", line_select, 0);
      checkOutput("t1_rd_en", rd_en, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (rd_en) begin
            n = i;
            break;
         end
      end
      checkOutput("t1_first_rd_en", n, 2);

      // Swap request raised mid-line 1 waits for the frame boundary.
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!oe_n && line_select == 1'b1) begin
            ok = 1;
            break;
         end
      end
      checkOutput("t5_reach_line1", ok, 1);
      @(posedge clk);
      #1 swap_req = 1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (swap_ack) begin
            ok = 1;
            break;
         end
      end
      checkOutput("t5_ack_seen", ok, 1);
      checkOutput("t5_ack_with_frame_start", frame_start, 1);
      @(posedge clk);
      #1 swap_req = 0;
      acks = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (swap_ack) acks++;
      end
      checkOutput("t5_no_repeat_ack", acks, 0);

      // Level held across two frame boundaries gives two acks.
      @(posedge clk);
      #1 swap_req = 1;
      acks = 0;
      starts = 0;
      for (int i = 0; i < 600 && starts < 2; i++) begin
         @(negedge clk);
         if (frame_start) starts++;
         if (swap_ack) acks++;
      end
      checkOutput("t5_two_frames", starts, 2);
      checkOutput("t5_two_acks", acks, 2);
      @(posedge clk);
      #1 swap_req = 0;

      // Randomized frames and swap traffic, scored by the pass-level model.
      @(posedge clk);
      #1 reset_n = 0;
      for (int i = 0; i < WORDS; i++) begin
         mem_top[i] = 6'($urandom);
         mem_bot[i] = 6'($urandom);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      for (int i = 0; i < 900; i++) begin
         @(posedge clk);
         #1;
         if (swap_ack && $urandom_range(0, 3) != 0) swap_req = 0;
         else if (!swap_req && $urandom_range(0, 39) == 0) swap_req = 1;
      end
      @(negedge clk);
      checkOutput("rand_progress", k >= 30, 1);
      checkOutput("slow_progress", s_k >= 6, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
